// File: rtl/tsn_pri_sched_if.sv
// Scheduler-side bundle: queue status and pMAC beat inputs, grant outputs.
interface tsn_pri_sched_if #(
  parameter int unsigned PORT_FIFO_PRI_NUM = 8
);
  localparam int unsigned QW = PORT_FIFO_PRI_NUM + 1;

  logic          i_sched_en;
  logic [QW-1:0] i_qav_mask;
  logic [QW-1:0] i_fifoc_empty;
  logic [QW-1:0] i_queque;
  logic          i_queque_vld;
  logic          i_pmac_tx_axis_valid;
  logic          i_pmac_tx_axis_last;
  logic [QW-1:0] o_scheduing_rst;
  logic          o_scheduing_rst_vld;
  logic          o_busy;
  logic          o_timeout;

  // Upstream side: Qav manager, crossbar flags and pMAC tap drive the inputs.
  modport master (
    output i_sched_en, i_qav_mask, i_fifoc_empty, i_queque, i_queque_vld,
           i_pmac_tx_axis_valid, i_pmac_tx_axis_last,
    input  o_scheduing_rst, o_scheduing_rst_vld, o_busy, o_timeout
  );

  // Scheduler side.
  modport slave (
    input  i_sched_en, i_qav_mask, i_fifoc_empty, i_queque, i_queque_vld,
           i_pmac_tx_axis_valid, i_pmac_tx_axis_last,
    output o_scheduing_rst, o_scheduing_rst_vld, o_busy, o_timeout
  );
endinterface

// File: rtl/tsn_pri_sched.sv
// Per-port strict-priority transmit scheduler with frame hold and stall watchdog.
module tsn_pri_sched #(
  parameter int unsigned PORT_FIFO_PRI_NUM = 8,
  parameter int unsigned TIMEOUT_CYC       = 1024
) (
  input logic            i_clk,
  input logic            i_rst,
  tsn_pri_sched_if.slave bus
);
  localparam int unsigned QW = PORT_FIFO_PRI_NUM + 1;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, BUSY = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] elig_q;
  logic [QW-1:0] cand;
  logic [QW-1:0] sel;
  logic [QW-1:0] grant_q, grant_d;
  logic          vld_q, vld_d;
  logic          busy_q, busy_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          beat;
  logic          eof;

  // Credit-eligibility snapshot from the Qav manager.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 elig_q <= '0;
    else if (bus.i_queque_vld) elig_q <= bus.i_queque;
  end

  // Sendable queues: non-empty, and either unshaped or credit-eligible.
  always_comb cand = ~bus.i_fifoc_empty & (~bus.i_qav_mask | elig_q);

  // One-hot of the highest-priority sendable queue.
  always_comb begin
    sel = '0;
    for (int i = 0; i < QW; i++) begin
      if (cand[i]) sel = QW'(1) << i;
    end
  end

  assign beat = bus.i_pmac_tx_axis_valid;
  assign eof  = bus.i_pmac_tx_axis_valid & bus.i_pmac_tx_axis_last;

  // State, registered outputs and watchdog counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state: arbitrate on the current cand, hold the grant until EOF or stall.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    vld_d   = 1'b0;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (bus.i_sched_en && (cand != '0)) state_d = ARB;
      end
      ARB: begin
        if (bus.i_sched_en && (sel != '0)) begin
          state_d = BUSY;
          grant_d = sel;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          wd_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (eof) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          wd_d    = '0;
        end else if (beat) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        wd_d    = '0;
      end
    endcase
  end

  assign bus.o_scheduing_rst     = grant_q;
  assign bus.o_scheduing_rst_vld = vld_q;
  assign bus.o_busy              = busy_q;
  assign bus.o_timeout           = tmo_q;
endmodule

// File: tb/tb_tsn_pri_sched.sv
// Self-checking bench for tsn_pri_sched: directed scenarios plus randomized frames.
module tb_tsn_pri_sched;
  localparam int unsigned N  = 8;
  localparam int unsigned QW = N + 1;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  tsn_pri_sched_if #(.PORT_FIFO_PRI_NUM(N)) b();

  tsn_pri_sched #(.PORT_FIFO_PRI_NUM(N), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (b)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {rst, vld, busy, timeout}.
  logic [QW+2:0] obs;
  logic [QW+2:0] exp;
  assign obs = {b.o_scheduing_rst, b.o_scheduing_rst_vld, b.o_busy, b.o_timeout};

  function automatic logic [QW+2:0] pk(logic [QW-1:0] r, logic v, logic bz, logic t);
    return {r, v, bz, t};
  endfunction

  // Reference pick: highest-indexed queue that is non-empty and unshaped or eligible.
  function automatic logic [QW-1:0] ref_pick(logic [QW-1:0] empty, logic [QW-1:0] mask,
                                             logic [QW-1:0] elig);
    for (int i = QW - 1; i >= 0; i--) begin
      if (!empty[i] && (!mask[i] || elig[i])) return QW'(1) << i;
    end
    return '0;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b.i_sched_en           = 1'b0;
    b.i_qav_mask           = '0;
    b.i_fifoc_empty        = '1;
    b.i_queque             = '0;
    b.i_queque_vld         = 1'b0;
    b.i_pmac_tx_axis_valid = 1'b0;
    b.i_pmac_tx_axis_last  = 1'b0;
  endtask

  task automatic end_frame_now();
    b.i_fifoc_empty = '1;
    b.i_pmac_tx_axis_valid = 1'b1;
    b.i_pmac_tx_axis_last  = 1'b1;
    nxt();
    b.i_pmac_tx_axis_valid = 1'b0;
    b.i_pmac_tx_axis_last  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) nxt();
    checks++; if (obs !== '0) begin errs++; $display("FAIL reset_hold got=%h want=%h", obs, '0); end
    rst = 1'b0;
    nxt(); nxt();
    checks++; if (obs !== '0) begin errs++; $display("FAIL reset_release got=%h want=%h", obs, '0); end
  endtask

  task automatic test_priority();
    b.i_sched_en = 1'b1; b.i_qav_mask = '0; b.i_fifoc_empty = 9'h1F6;
    nxt();
    exp = pk('0, 0, 0, 0);
    checks++; if (obs !== exp) begin errs++; $display("FAIL prio_arb got=%h want=%h", obs, exp); end
    nxt();
    exp = pk(9'h008, 1, 1, 0);
    checks++; if (obs !== exp) begin errs++; $display("FAIL prio_grant got=%h want=%h", obs, exp); end
    b.i_fifoc_empty = '1;
    repeat (3) nxt();
    exp = pk(9'h008, 0, 1, 0);
    checks++; if (obs !== exp) begin errs++; $display("FAIL prio_hold got=%h want=%h", obs, exp); end
    end_frame_now();
    checks++; if (obs !== '0) begin errs++; $display("FAIL prio_end got=%h want=%h", obs, '0); end
  endtask

  task automatic test_qav();
    rst = 1'b1; nxt(); rst = 1'b0; nxt();
    b.i_sched_en = 1'b1; b.i_fifoc_empty = 9'h0FF; b.i_qav_mask = 9'h100;
    repeat (4) begin
      nxt();
      checks++; if (obs !== '0) begin errs++; $display("FAIL qav_blocked got=%h want=%h", obs, '0); end
    end
    b.i_queque = 9'h100; b.i_queque_vld = 1'b1;
    nxt();
    b.i_queque_vld = 1'b0;
    checks++; if (obs !== '0) begin errs++; $display("FAIL qav_c1 got=%h want=%h", obs, '0); end
    nxt();
    checks++; if (obs !== '0) begin errs++; $display("FAIL qav_c2 got=%h want=%h", obs, '0); end
    nxt();
    exp = pk(9'h100, 1, 1, 0);
    checks++; if (obs !== exp) begin errs++; $display("FAIL qav_grant got=%h want=%h", obs, exp); end
    end_frame_now();
    b.i_qav_mask = '0;
    checks++; if (obs !== '0) begin errs++; $display("FAIL qav_end got=%h want=%h", obs, '0); end
  endtask

  task automatic test_frame_hold();
    b.i_sched_en = 1'b1; b.i_fifoc_empty = 9'h1FB;
    nxt(); nxt();
    exp = pk(9'h004, 1, 1, 0);
    checks++; if (obs !== exp) begin errs++; $display("FAIL hold_grant got=%h want=%h", obs, exp); end
    b.i_fifoc_empty = 9'h1BB;
    for (int bt = 1; bt <= 10; bt++) begin
      if (bt > 1) begin
        exp = pk(9'h004, 0, 1, 0);
        checks++; if (obs !== exp) begin errs++; $display("FAIL hold_beat%0d got=%h want=%h", bt, obs, exp); end
      end
      b.i_pmac_tx_axis_valid = 1'b1;
      b.i_pmac_tx_axis_last  = (bt == 10);
      nxt();
    end
    b.i_pmac_tx_axis_valid = 1'b0; b.i_pmac_tx_axis_last = 1'b0;
    checks++; if (obs !== '0) begin errs++; $display("FAIL hold_release got=%h want=%h", obs, '0); end
    nxt();
    checks++; if (obs !== '0) begin errs++; $display("FAIL hold_rearb got=%h want=%h", obs, '0); end
    nxt();
    exp = pk(9'h040, 1, 1, 0);
    checks++; if (obs !== exp) begin errs++; $display("FAIL hold_next got=%h want=%h", obs, exp); end
    end_frame_now();
  endtask

  task automatic test_disappear();
    b.i_sched_en = 1'b1; b.i_fifoc_empty = 9'h1FD;
    nxt();
    b.i_fifoc_empty = '1;
    repeat (3) begin
      nxt();
      checks++; if (obs !== '0) begin errs++; $display("FAIL gone_nogrant got=%h want=%h", obs, '0); end
    end
    b.i_fifoc_empty = 9'h1FD;
    nxt();
    checks++; if (obs !== '0) begin errs++; $display("FAIL gone_idle got=%h want=%h", obs, '0); end
    nxt();
    exp = pk(9'h002, 1, 1, 0);
    checks++; if (obs !== exp) begin errs++; $display("FAIL gone_regrant got=%h want=%h", obs, exp); end
    end_frame_now();
  endtask

  // beat_at = BUSY cycle carrying one non-last beat, 0 for none.
  task automatic test_watchdog(input int beat_at);
    int limit;
    limit = (beat_at == 0) ? TO : beat_at + TO;
    b.i_sched_en = 1'b1; b.i_fifoc_empty = 9'h1FD;
    nxt(); nxt();
    b.i_fifoc_empty = '1;
    for (int n = 1; n <= limit; n++) begin
      exp = pk(9'h002, n == 1, 1, 0);
      checks++; if (obs !== exp) begin errs++; $display("FAIL wd_busy n=%0d got=%h want=%h", n, obs, exp); end
      b.i_pmac_tx_axis_valid = (n == beat_at);
      nxt();
      b.i_pmac_tx_axis_valid = 1'b0;
    end
    exp = pk('0, 0, 0, 1);
    checks++; if (obs !== exp) begin errs++; $display("FAIL wd_timeout got=%h want=%h", obs, exp); end
    nxt();
    checks++; if (obs !== '0) begin errs++; $display("FAIL wd_pulse_end got=%h want=%h", obs, '0); end
  endtask

  task automatic test_reset_mid();
    b.i_sched_en = 1'b1; b.i_fifoc_empty = 9'h1F7;
    nxt(); nxt();
    b.i_fifoc_empty = '1;
    nxt(); nxt();
    exp = pk(9'h008, 0, 1, 0);
    checks++; if (obs !== exp) begin errs++; $display("FAIL rstmid_busy got=%h want=%h", obs, exp); end
    #2 rst = 1'b1;
    #1;
    checks++; if (obs !== '0) begin errs++; $display("FAIL rstmid_async got=%h want=%h", obs, '0); end
    nxt();
    checks++; if (obs !== '0) begin errs++; $display("FAIL rstmid_hold got=%h want=%h", obs, '0); end
    rst = 1'b0;
    nxt();
    checks++; if (obs !== '0) begin errs++; $display("FAIL rstmid_after got=%h want=%h", obs, '0); end
  endtask

  task automatic test_enable();
    b.i_sched_en = 1'b1; b.i_fifoc_empty = 9'h1EF;
    nxt(); nxt();
    exp = pk(9'h010, 1, 1, 0);
    checks++; if (obs !== exp) begin errs++; $display("FAIL en_grant got=%h want=%h", obs, exp); end
    for (int n = 1; n <= 6; n++) begin
      if (n == 2) b.i_sched_en = 1'b0;
      b.i_pmac_tx_axis_valid = (n % 2 == 0);
      b.i_pmac_tx_axis_last  = (n == 6);
      nxt();
      b.i_pmac_tx_axis_valid = 1'b0; b.i_pmac_tx_axis_last = 1'b0;
      if (n < 6) begin
        exp = pk(9'h010, 0, 1, 0);
        checks++; if (obs !== exp) begin errs++; $display("FAIL en_hold n=%0d got=%h want=%h", n, obs, exp); end
      end
    end
    checks++; if (obs !== '0) begin errs++; $display("FAIL en_frame_done got=%h want=%h", obs, '0); end
    repeat (6) begin
      nxt();
      checks++; if (obs !== '0) begin errs++; $display("FAIL en_blocked got=%h want=%h", obs, '0); end
    end
    b.i_sched_en = 1'b1;
    nxt();
    checks++; if (obs !== '0) begin errs++; $display("FAIL en_arb got=%h want=%h", obs, '0); end
    nxt();
    exp = pk(9'h010, 1, 1, 0);
    checks++; if (obs !== exp) begin errs++; $display("FAIL en_resume got=%h want=%h", obs, exp); end
    end_frame_now();
  endtask

  task automatic test_random();
    logic [QW-1:0] elig, empty, mask, win;
    int len, beats, gap, n;
    for (int it = 0; it < 40; it++) begin
      elig = QW'($urandom);
      b.i_queque = elig; b.i_queque_vld = 1'b1;
      nxt();
      b.i_queque_vld = 1'b0;
      empty = QW'($urandom); mask = QW'($urandom);
      win = ref_pick(empty, mask, elig);
      b.i_fifoc_empty = empty; b.i_qav_mask = mask; b.i_sched_en = 1'b1;
      nxt();
      checks++; if (obs !== '0) begin errs++; $display("FAIL rand_arb it=%0d got=%h want=%h", it, obs, '0); end
      nxt();
      if (win == '0) begin
        checks++; if (obs !== '0) begin errs++; $display("FAIL rand_none it=%0d got=%h want=%h", it, obs, '0); end
        b.i_fifoc_empty = '1;
        nxt();
      end else begin
        len = $urandom_range(1, 5); beats = 0; gap = 0; n = 0;
        while (beats < len) begin
          exp = pk(win, n == 0, 1, 0);
          checks++; if (obs !== exp) begin errs++; $display("FAIL rand_busy it=%0d n=%0d got=%h want=%h", it, n, obs, exp); end
          b.i_pmac_tx_axis_valid = (gap >= 4) || ($urandom_range(0, 3) != 0);
          b.i_pmac_tx_axis_last  = b.i_pmac_tx_axis_valid && (beats == len - 1);
          if (b.i_pmac_tx_axis_valid) begin beats++; gap = 0; end else gap++;
          b.i_fifoc_empty = b.i_pmac_tx_axis_last ? '1 : QW'($urandom);
          if ($urandom_range(0, 7) == 0) b.i_sched_en = 1'b0;
          nxt();
          b.i_pmac_tx_axis_valid = 1'b0; b.i_pmac_tx_axis_last = 1'b0;
          n++;
        end
        checks++; if (obs !== '0) begin errs++; $display("FAIL rand_end it=%0d got=%h want=%h", it, obs, '0); end
      end
      b.i_qav_mask = '0;
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_qav();
    test_frame_hold();
    test_disappear();
    test_watchdog(0);
    test_watchdog(10);
    test_reset_mid();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/tsn_pri_sched.md
# tsn_pri_sched

Per-port transmit scheduler for the TxMAC scheduling pipeline. It takes the credit-eligible queue vector from the Qav credit manager and the crossbar priority-FIFO empty flags, and picks the highest-priority sendable queue. It issues a one-hot scheduling result with a valid pulse, which feeds back into the Qav manager and the port read logic. It then holds that grant until the pMAC AXI-Stream frame ends, or until a stall watchdog fires.

## Interface
- PORT_FIFO_PRI_NUM, 8, highest queue index. Every queue vector is PORT_FIFO_PRI_NUM+1 bits wide, and a higher index means a higher priority.
- TIMEOUT_CYC, 1024, number of BUSY cycles without a pMAC beat before the grant is aborted. Legal range is 2..65535.

Ports:
- i_clk  in  1  250 MHz clock.
- i_rst  in  1  Asynchronous, active-high reset.
- i_sched_en  in  1  Enables new grants.
- i_qav_mask  in  N+1  Bit set means the queue is CBS-shaped and needs Qav eligibility.
- i_fifoc_empty  in  N+1  Crossbar priority-FIFO empty flags.
- i_queque  in  N+1  Credit-eligible queue vector from the Qav manager.
- i_queque_vld  in  1  Update strobe for i_queque.
- i_pmac_tx_axis_valid  in  1  pMAC transmit beat valid.
- i_pmac_tx_axis_last  in  1  pMAC transmit last beat.
- o_scheduing_rst  out  N+1  One-hot granted queue. It is 0 when nothing is granted.
- o_scheduing_rst_vld  out  1  One-cycle grant pulse.
- o_busy  out  1  High while a frame is granted.
- o_timeout  out  1  One-cycle pulse on watchdog abort.

## Operation
- Eligibility register elig_q:
  - Loads i_queque on any cycle where i_queque_vld=1.
  - Otherwise holds its value.
  - Reset value is 0.
- Candidate vector: cand = ~i_fifoc_empty & (~i_qav_mask | elig_q). This is combinational.
- Selection: sel = one-hot of the highest set bit of cand, or 0 if cand is 0.
- FSM states: IDLE, ARB, BUSY.
  - IDLE → ARB when i_sched_en=1 and cand≠0.
  - ARB re-evaluates cand in its own cycle.
    - If i_sched_en=0 or sel=0 → IDLE, with no pulse.
    - Otherwise, at the ARB→BUSY edge, register o_scheduing_rst<=sel and o_scheduing_rst_vld<=1.
  - BUSY: o_scheduing_rst and o_busy are held. o_scheduing_rst_vld is high only in the first BUSY cycle.
    - A beat is i_pmac_tx_axis_valid=1. The end of frame is valid&last.
    - On end of frame → IDLE. At that edge, clear o_scheduing_rst to 0 and o_busy to 0.
- Watchdog counter, 16 bits:
  - Cleared on entry to BUSY and on every beat.
  - Increments in each BUSY cycle that has no beat.
  - When it reaches TIMEOUT_CYC-1 in a no-beat cycle → IDLE, pulse o_timeout for one cycle, and clear o_scheduing_rst.
- Deasserting i_sched_en during BUSY does not abort the frame; it only blocks the next grant.
- Changes to cand during BUSY are ignored. Re-arbitration happens only after the return to IDLE.

## Timing
- Reset values: every output is 0, state is IDLE, elig_q is 0, and the counter is 0.
- Grant latency: cand≠0 sampled at edge k in IDLE → ARB during cycle k+1 → o_scheduing_rst_vld high in cycle k+2. That is 2 cycles minimum.
- Back-to-back grants: end of frame in cycle j → IDLE in cycle j+1 → earliest next vld in cycle j+3. Minimum spacing between grants is 3 cycles when frames are single-beat.
- A single-beat frame (valid&last) in the same cycle as the vld pulse is legal. It ends BUSY after exactly one cycle.
- i_queque_vld in cycle k affects cand from cycle k+1.
- The selected queue going empty or ineligible before ARB is handled: ARB uses its current-cycle cand, so no stale grant is issued.
- Asynchronous reset mid-BUSY clears all outputs immediately, with no o_timeout pulse.
- The vld and timeout pulses never coincide.

## Test plan
- Priority pick: i_fifoc_empty=9'h1F6, i_qav_mask=0, en=1 → o_scheduing_rst=9'h008, vld pulse exactly 2 cycles after the inputs settle, o_busy=1 until valid&last.
- Qav gating:
  - i_fifoc_empty=9'h0FF and i_qav_mask=9'h100, with elig_q=0 → no grant.
  - Then i_queque=9'h100 with i_queque_vld=1 → o_scheduing_rst=9'h100 and vld 3 cycles after the strobe.
- Frame hold: grant 9'h004, then a higher queue becomes non-empty during a 10-beat frame → o_scheduing_rst stays at 9'h004. On the cycle after the last beat, it goes to 0. The next vld grants the higher queue 2 cycles later.
- Disappearing candidate: cand=9'h002 for one cycle only (empty again in ARB) → no vld; FSM returns to IDLE.
- Watchdog: TIMEOUT_CYC=16, grant issued, no beats → o_timeout pulse on the 16th BUSY cycle, o_scheduing_rst=0 and o_busy=0 on the following cycle. Repeat with one beat at BUSY cycle 10 → no timeout until BUSY cycle 26.
- Reset and enable:
  - i_rst asserted mid-BUSY → all outputs 0 immediately.
  - i_sched_en=0 mid-frame → the frame completes and no further vld is issued while en=0.
